ysyx_24100005_lsu: RTL and testbench
====================================

Name:
ysyx_24100005_lsu

Overview:
- Multi-cycle load/store unit for the NPC core. Replaces the combinational DPI memory access with a registered valid/ready memory port.
- Accepts one load/store from the core at a time. Performs address alignment, generates byte strobes and lane-shifted write data, and sign/zero-extends load data.
- Adds misalignment detection and a response timeout.
- Sits between the execute stage, which supplies the adder output as address, and the memory/bus adapter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory/register data width; legal values 32 or 64.
- TIMEOUT_CYC, 16, maximum cycles spent in WAIT before an error response; legal range 1..255.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a memory op
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load result; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal funct3, or timeout; qualified by rsp_valid
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  req_addr with the low log2(DATA_W/8) bits cleared
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_wstrb  out  DATA_W/8  byte strobes
- mem_rsp_valid  in  1  read data valid / write acknowledge
- mem_rdata  in  DATA_W  full-width read data

Behaviour:
- Reset values: state IDLE; req_ready=1; all other outputs 0; timeout counter 0. Reset applies from any state; a pending memory transaction is abandoned.
- State machine:
  - IDLE: req_ready=1. On req_valid, latch we, funct3, addr, wdata and byte offset off = addr[OFF_W-1:0]. If the request is illegal, go to RESP with err=1. Otherwise go to REQ.
  - REQ: mem_req_valid=1; mem_addr, mem_we, mem_wdata, mem_wstrb stay stable until mem_req_ready. On the handshake, go to WAIT and clear the counter.
  - WAIT: sample mem_rsp_valid. Loads capture the extended data; stores capture nothing. Then go to RESP.
    - The counter increments every WAIT cycle. When it reaches TIMEOUT_CYC without mem_rsp_valid, go to RESP with err=1.
  - RESP: rsp_valid=1 for exactly one cycle. rsp_rdata/rsp_err come from registers. Next state IDLE.
- Timing rules:
  - mem_rsp_valid is ignored outside WAIT; the memory must not respond in the same cycle as the request handshake.
  - No response back-pressure; the core stalls on !rsp_valid.
  - Minimum latency: accept at cycle 0, REQ cycle 1 with ready, response cycle 2, rsp_valid in cycle 3.
  - Illegal requests: rsp_valid in cycle 1; mem_req_valid never asserts.
- Size from funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 8 bytes.
  - funct3[2]=1 means unsigned load: LBU, LHU, LWU.
- Illegal requests:
  - Size 11 when DATA_W=32.
  - funct3 110 when DATA_W=32.
  - funct3 111 in any configuration.
  - Any store with funct3[2]=1.
  - Address not a multiple of the size.
- Store lanes:
  - mem_wstrb = ((1<<size_bytes)-1) << off.
  - mem_wdata = req_wdata << (8*off); bits outside the strobes are don't-care and driven as the shifted value.
  - On a load, mem_wstrb=0 and mem_wdata=0.
- Load extract: shifted = mem_rdata >> (8*off), truncated to the access size, then sign-extended (funct3[2]=0) or zero-extended to DATA_W.
- rsp_rdata is 0 whenever rsp_valid=0.

Decomposition:
- Shared package ysyx_24100005_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - the LSU state enum (IDLE/REQ/WAIT/RESP);
  - the RISC-V opcode constants (LOAD 7'b0000011, STORE 7'b0100011).
- One combinational sub-module, ysyx_24100005_lsu_align, contains the strobe/shift generation and load extraction/extension. This allows it to be unit-tested exhaustively apart from the FSM.

Test Plan:
- LB, addr 0x80000003, mem_rdata 0x8A000000, DATA_W=32 -> mem_addr 0x80000000, mem_wstrb 0, rsp_rdata 0xFFFFFF8A, rsp_err 0, rsp_valid at cycle 3 with mem_req_ready high immediately and mem_rsp_valid on the first WAIT cycle.
- SH, wdata 0x1234ABCD, addr 0x80000002 -> mem_we 1, mem_wstrb 4'b1100, mem_wdata 0xABCD0000, rsp_rdata 0.
- LHU, addr 0x80000002, mem_rdata 0xF00D1234 -> rsp_rdata 0x0000F00D. Same with LH -> 0xFFFFF00D.
- LW at 0x80000002, and SB with funct3 100 -> rsp_valid with rsp_err 1 one cycle after accept; mem_req_valid stays 0.
- mem_req_ready low for 5 cycles, then mem_rsp_valid 3 cycles after the handshake -> mem_req_valid and mem_addr stable throughout, rsp_valid exactly once, err 0. Memory silent, TIMEOUT_CYC=16 -> rsp_err 1 after 16 WAIT cycles, and a later stray mem_rsp_valid is ignored.
- rst driven low in WAIT -> all outputs 0 immediately and req_ready 1. After release, a late mem_rsp_valid produces no rsp_valid, and a DATA_W=64 LD at 0x80000008 (mem_rdata 0x8000000000000001) returns that full value.

Source files
------------

// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the NPC load/store path.
// Contents: funct3 encodings for loads/stores, the LSU state encoding,
// and the RISC-V major opcodes for LOAD and STORE.
package ysyx_24100005_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational lane logic for the LSU.
// Stores: byte strobes and store data shifted into the addressed lanes.
// Loads:  full-width read data shifted down to the addressed byte, cut to
//         the access size and sign- or zero-extended.
// Ports:
//   funct3    in  access funct3 (size in [1:0], unsigned flag in [2])
//   we        in  1 = store; strobes/write data are zero for loads
//   off       in  byte offset within the memory word
//   wdata     in  right-aligned store data
//   rdata     in  full-width memory read data
//   wstrb     out byte strobes
//   wdata_sh  out lane-shifted store data
//   rdata_ext out extended load result
module ysyx_24100005_lsu_align
  import ysyx_24100005_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        funct3,
  input  logic              we,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     wstrb,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] shifted;
  logic              msb;
  int                nbytes;
  int                nbits;

  always_comb begin
    nbytes = 1 << funct3[1:0];
    mask   = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (i < nbytes);
    end
    wstrb    = we ? (mask << off) : '0;
    wdata_sh = we ? (wdata << {off, 3'b000}) : '0;
  end

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    nbits   = 8 << funct3[1:0];
    case (funct3[1:0])
      2'b00:   msb = shifted[7];
      2'b01:   msb = shifted[15];
      2'b10:   msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    rdata_ext = '0;
    // Bits above the access size take the sign bit unless the load is unsigned.
    for (int i = 0; i < DATA_W; i++) begin
      rdata_ext[i] = (i < nbits) ? shifted[i] : (~funct3[2] & msb);
    end
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit between execute and the memory adapter.
// One request at a time; illegal requests (bad funct3, misaligned) are
// answered with an error without touching memory; a silent memory is cut
// off after TIMEOUT_CYC wait cycles with an error.
// Ports:
//   clk, rst (async, active low)
//   req_*  core request (valid/ready, we, funct3, addr, wdata)
//   rsp_*  one-cycle completion pulse with load data / error
//   mem_*  registered valid/ready memory port, response via mem_rsp_valid
//
// state | meaning
// IDLE  | ready for a core request
// REQ   | memory request held until mem_req_ready
// WAIT  | waiting for mem_rsp_valid or timeout
// RESP  | rsp_valid pulse
module ysyx_24100005_lsu
  import ysyx_24100005_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              bad_f3;
  logic              misaligned;
  logic              illegal;
  logic [NB-1:0]     strb_lane;
  logic [DATA_W-1:0] wdata_lane;
  logic [DATA_W-1:0] rdata_ext;

  always_comb begin
    bad_f3 = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    if (DATA_W == 32) begin
      bad_f3 = bad_f3 || (req_funct3[1:0] == 2'b11) || (req_funct3 == F3_WU);
    end
    case (req_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    illegal = bad_f3 || misaligned;
  end

  ysyx_24100005_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .funct3    (f3_q),
    .we        (we_q),
    .off       (addr_q[OFF_W-1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wstrb     (strb_lane),
    .wdata_sh  (wdata_lane),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = illegal;
          state_d = illegal ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rsp_valid) begin
          rdata_d = we_q ? '0 : rdata_ext;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are forced to zero outside REQ so a reset or idle
  // LSU presents nothing on the bus.
  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = mem_req_valid & we_q;
  assign mem_addr      = mem_req_valid ? (addr_q & ALIGN_MASK) : '0;
  assign mem_wstrb     = mem_req_valid ? strb_lane : '0;
  assign mem_wdata     = mem_req_valid ? wdata_lane : '0;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rsp_valid ? rdata_q : '0;
  assign rsp_err       = rsp_valid & err_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
module tb_ysyx_24100005_lsu;
  import ysyx_24100005_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid32 = 1'b0, req_we32 = 1'b0;
  logic [2:0]  req_funct3_32 = 3'b000;
  logic [31:0] req_addr32 = '0, req_wdata32 = '0;
  logic        req_ready32, rsp_valid32, rsp_err32;
  logic [31:0] rsp_rdata32;
  logic        mem_req_valid32, mem_we32;
  logic        mem_req_ready32 = 1'b0, mem_rsp_valid32 = 1'b0;
  logic [31:0] mem_addr32, mem_wdata32;
  logic [31:0] mem_rdata32 = '0;
  logic [3:0]  mem_wstrb32;

  // 64-bit instance
  logic        req_valid64 = 1'b0, req_we64 = 1'b0;
  logic [2:0]  req_funct3_64 = 3'b000;
  logic [31:0] req_addr64 = '0;
  logic [63:0] req_wdata64 = '0;
  logic        req_ready64, rsp_valid64, rsp_err64;
  logic [63:0] rsp_rdata64;
  logic        mem_req_valid64, mem_we64;
  logic        mem_req_ready64 = 1'b0, mem_rsp_valid64 = 1'b0;
  logic [31:0] mem_addr64;
  logic [63:0] mem_wdata64;
  logic [63:0] mem_rdata64 = '0;
  logic [7:0]  mem_wstrb64;

  ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) u_lsu32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_we(req_we32),
    .req_funct3(req_funct3_32), .req_addr(req_addr32), .req_wdata(req_wdata32),
    .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32),
    .mem_req_valid(mem_req_valid32), .mem_req_ready(mem_req_ready32), .mem_we(mem_we32),
    .mem_addr(mem_addr32), .mem_wdata(mem_wdata32), .mem_wstrb(mem_wstrb32),
    .mem_rsp_valid(mem_rsp_valid32), .mem_rdata(mem_rdata32)
  );

  ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(16)) u_lsu64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
    .req_funct3(req_funct3_64), .req_addr(req_addr64), .req_wdata(req_wdata64),
    .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64),
    .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready64), .mem_we(mem_we64),
    .mem_addr(mem_addr64), .mem_wdata(mem_wdata64), .mem_wstrb(mem_wstrb64),
    .mem_rsp_valid(mem_rsp_valid64), .mem_rdata(mem_rdata64)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expected responses pushed at request time, popped on rsp_valid.
  logic [31:0] q_rdata32[$];
  logic        q_err32[$];
  string       q_tag32[$];
  logic [63:0] q_rdata64[$];
  logic        q_err64[$];
  string       q_tag64[$];
  string       mon_tag32, mon_tag64;

  always @(negedge clk) begin
    if (rsp_valid32 === 1'b1) begin
      if (q_rdata32.size() == 0) begin
        chk("rsp32_unexpected", {63'd0, rsp_valid32}, 64'd0);
      end else begin
        mon_tag32 = q_tag32.pop_front();
        chk({mon_tag32, "/rdata"}, {32'd0, rsp_rdata32}, {32'd0, q_rdata32.pop_front()});
        chk({mon_tag32, "/err"}, {63'd0, rsp_err32}, {63'd0, q_err32.pop_front()});
      end
    end
    if (rsp_valid64 === 1'b1) begin
      if (q_rdata64.size() == 0) begin
        chk("rsp64_unexpected", {63'd0, rsp_valid64}, 64'd0);
      end else begin
        mon_tag64 = q_tag64.pop_front();
        chk({mon_tag64, "/rdata"}, rsp_rdata64, q_rdata64.pop_front());
        chk({mon_tag64, "/err"}, {63'd0, rsp_err64}, {63'd0, q_err64.pop_front()});
      end
    end
  end

  // One 32-bit transaction. rdy_dly: REQ cycles before mem_req_ready;
  // rsp_dly: WAIT cycles before mem_rsp_valid; silent: memory never answers.
  task automatic run32(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mrdata, input int rdy_dly, input int rsp_dly,
                       input bit silent, input bit legal, input logic [31:0] exp_rdata,
                       input bit exp_err, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata);
    int waits;
    bit got;
    q_rdata32.push_back(exp_rdata);
    q_err32.push_back(exp_err);
    q_tag32.push_back(tag);
    chk({tag, "/req_ready"}, {63'd0, req_ready32}, 64'd1);
    req_valid32 = 1'b1;
    req_we32 = we;
    req_funct3_32 = f3;
    req_addr32 = addr;
    req_wdata32 = wdata;
    step();
    req_valid32 = 1'b0;
    req_wdata32 = 32'h5A5A5A5A;
    if (!legal) begin
      chk({tag, "/rsp_cycle1"}, {63'd0, rsp_valid32}, 64'd1);
      chk({tag, "/no_mem_req"}, {63'd0, mem_req_valid32}, 64'd0);
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        chk({tag, "/mem_req_valid"}, {63'd0, mem_req_valid32}, 64'd1);
        chk({tag, "/mem_addr"}, {32'd0, mem_addr32}, {32'd0, addr[31:2], 2'b00});
        chk({tag, "/mem_we"}, {63'd0, mem_we32}, {63'd0, we});
        chk({tag, "/mem_wstrb"}, {60'd0, mem_wstrb32}, {60'd0, exp_strb});
        chk({tag, "/mem_wdata"}, {32'd0, mem_wdata32}, {32'd0, exp_wdata});
        if (k == rdy_dly) mem_req_ready32 = 1'b1;
        step();
      end
      mem_req_ready32 = 1'b0;
      waits = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        chk({tag, "/wait_no_mem_req"}, {63'd0, mem_req_valid32}, 64'd0);
        if (!silent && k == rsp_dly) begin
          mem_rsp_valid32 = 1'b1;
          mem_rdata32 = mrdata;
        end
        step();
        mem_rsp_valid32 = 1'b0;
        mem_rdata32 = 32'hDEADBEEF;
        waits++;
        if (rsp_valid32 === 1'b1) got = 1'b1;
      end
      chk({tag, "/wait_cycles"}, 64'(waits), silent ? 64'd16 : 64'(rsp_dly + 1));
    end
    step();
    chk({tag, "/rsp_once"}, {63'd0, rsp_valid32}, 64'd0);
    chk({tag, "/rdata_idle0"}, {32'd0, rsp_rdata32}, 64'd0);
    chk({tag, "/ready_again"}, {63'd0, req_ready32}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    #12;
    chk("reset_req_ready", {63'd0, req_ready32}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid32}, 64'd0);
    chk("reset_mem_req_valid", {63'd0, mem_req_valid32}, 64'd0);
    chk("reset_mem_addr", {32'd0, mem_addr32}, 64'd0);
    rst = 1'b1;
    step();

    //    tag       we    f3      addr          wdata         mrdata     rdy rsp sil legal exp_rdata   err  strb     wdata
    run32("LB",     1'b0, F3_B,   32'h80000003, 32'h0,        32'h8A000000, 0, 0, 0, 1, 32'hFFFFFF8A, 0, 4'b0000, 32'h0);
    run32("SH",     1'b1, F3_H,   32'h80000002, 32'h1234ABCD, 32'h0,        0, 0, 0, 1, 32'h0,        0, 4'b1100, 32'hABCD0000);
    run32("LHU",    1'b0, F3_HU,  32'h80000002, 32'h0,        32'hF00D1234, 0, 0, 0, 1, 32'h0000F00D, 0, 4'b0000, 32'h0);
    run32("LH",     1'b0, F3_H,   32'h80000002, 32'h0,        32'hF00D1234, 0, 0, 0, 1, 32'hFFFFF00D, 0, 4'b0000, 32'h0);
    run32("LBU",    1'b0, F3_BU,  32'h80000001, 32'h0,        32'h0000FF00, 0, 1, 0, 1, 32'h000000FF, 0, 4'b0000, 32'h0);
    run32("SB",     1'b1, F3_B,   32'h80000001, 32'h777777A5, 32'h0,        2, 0, 0, 1, 32'h0,        0, 4'b0010, 32'h7777A500);
    run32("SW",     1'b1, F3_W,   32'h80000004, 32'hCAFEF00D, 32'h0,        0, 0, 0, 1, 32'h0,        0, 4'b1111, 32'hCAFEF00D);
    run32("LW_mis", 1'b0, F3_W,   32'h80000002, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0);
    run32("SB_u",   1'b1, F3_BU,  32'h80000000, 32'h11,       32'h0,        0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0);
    run32("LD_32",  1'b0, F3_D,   32'h80000000, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0);
    run32("F3_111", 1'b0, 3'b111, 32'h80000000, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        1, 4'b0000, 32'h0);
    run32("LW_slow",1'b0, F3_W,   32'h80000010, 32'h0,        32'h12345678, 5, 3, 0, 1, 32'h12345678, 0, 4'b0000, 32'h0);
    run32("LW_tmo", 1'b0, F3_W,   32'h80000020, 32'h0,        32'h0,        0, 0, 1, 1, 32'h0,        1, 4'b0000, 32'h0);

    // stray memory response while idle must be ignored
    mem_rsp_valid32 = 1'b1;
    mem_rdata32 = 32'h13572468;
    step();
    mem_rsp_valid32 = 1'b0;
    chk("stray_no_rsp", {63'd0, rsp_valid32}, 64'd0);
    chk("stray_still_ready", {63'd0, req_ready32}, 64'd1);
    step();
    chk("stray_no_rsp2", {63'd0, rsp_valid32}, 64'd0);

    // reset asserted while waiting for memory
    req_valid32 = 1'b1;
    req_we32 = 1'b1;
    req_funct3_32 = F3_W;
    req_addr32 = 32'h80000004;
    req_wdata32 = 32'hA5A5A5A5;
    step();
    req_valid32 = 1'b0;
    mem_req_ready32 = 1'b1;
    step();
    mem_req_ready32 = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", {63'd0, req_ready32}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid32}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err32}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata32}, 64'd0);
    chk("rst_mem_req_valid", {63'd0, mem_req_valid32}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we32}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr32}, 64'd0);
    chk("rst_mem_wstrb", {60'd0, mem_wstrb32}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata32}, 64'd0);
    step();
    rst = 1'b1;
    step();
    mem_rsp_valid32 = 1'b1;
    step();
    mem_rsp_valid32 = 1'b0;
    chk("late_rsp_ignored", {63'd0, rsp_valid32}, 64'd0);
    step();
    chk("late_rsp_ignored2", {63'd0, rsp_valid32}, 64'd0);

    // 64-bit LD after reset release
    q_rdata64.push_back(64'h8000000000000001);
    q_err64.push_back(1'b0);
    q_tag64.push_back("LD64");
    chk("LD64/req_ready", {63'd0, req_ready64}, 64'd1);
    req_valid64 = 1'b1;
    req_we64 = 1'b0;
    req_funct3_64 = F3_D;
    req_addr64 = 32'h80000008;
    step();
    req_valid64 = 1'b0;
    chk("LD64/mem_req_valid", {63'd0, mem_req_valid64}, 64'd1);
    chk("LD64/mem_addr", {32'd0, mem_addr64}, 64'h80000008);
    chk("LD64/mem_wstrb", {56'd0, mem_wstrb64}, 64'd0);
    mem_req_ready64 = 1'b1;
    step();
    mem_req_ready64 = 1'b0;
    mem_rsp_valid64 = 1'b1;
    mem_rdata64 = 64'h8000000000000001;
    step();
    mem_rsp_valid64 = 1'b0;
    mem_rdata64 = '0;
    chk("LD64/rsp_valid", {63'd0, rsp_valid64}, 64'd1);
    step();
    chk("LD64/rsp_once", {63'd0, rsp_valid64}, 64'd0);

    step();
    chk("q32_drained", 64'(q_rdata32.size()), 64'd0);
    chk("q64_drained", 64'(q_rdata64.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
